// File: rtl/emesh_rx_merge_if.sv
// Bundle of the three elink receive streams, the merged emesh output and the
// debug accept counters for emesh_rx_merge.
interface emesh_rx_merge_if #(
    parameter int PW = 104,
    parameter int CW = 16
);
    logic          rxwr_access;
    logic [PW-1:0] rxwr_packet;
    logic          rxwr_wait;
    logic          rxrd_access;
    logic [PW-1:0] rxrd_packet;
    logic          rxrd_wait;
    logic          rxrr_access;
    logic [PW-1:0] rxrr_packet;
    logic          rxrr_wait;
    logic          access_out;
    logic [PW-1:0] packet_out;
    logic          wait_in;
    logic [CW-1:0] cnt_wr;
    logic [CW-1:0] cnt_rd;
    logic [CW-1:0] cnt_rr;

    // Environment side: drives the sources and the consumer pushback.
    modport master (
        output rxwr_access, rxwr_packet, rxrd_access, rxrd_packet,
               rxrr_access, rxrr_packet, wait_in,
        input  rxwr_wait, rxrd_wait, rxrr_wait, access_out, packet_out,
               cnt_wr, cnt_rd, cnt_rr
    );

    // Merge block side.
    modport slave (
        input  rxwr_access, rxwr_packet, rxrd_access, rxrd_packet,
               rxrr_access, rxrr_packet, wait_in,
        output rxwr_wait, rxrd_wait, rxrr_wait, access_out, packet_out,
               cnt_wr, cnt_rd, cnt_rr
    );
endinterface

// File: rtl/emesh_rx_merge.sv
// Merges the elink rxwr/rxrd/rxrr master streams into one registered emesh
// stream with round-robin (or fixed) arbitration and per-source accept counters.
module emesh_rx_merge #(
    parameter int PW    = 104,
    parameter int CW    = 16,
    parameter int FIXED = 0
) (
    input logic           clk,
    input logic           reset,
    emesh_rx_merge_if.slave bus
);
    logic [2:0]    acc;
    logic [2:0]    gnt;
    logic [2:0]    acpt;
    logic [1:0]    ptr;
    logic [PW-1:0] pkt_sel;

    assign acc  = {bus.rxrr_access, bus.rxrd_access, bus.rxwr_access};
    assign acpt = gnt & {3{~bus.wait_in}};

    // Index 0=wr, 1=rd, 2=rr; round-robin scans upward from ptr modulo 3.
    always_comb begin
        gnt = '0;
        if (FIXED != 0) begin
            if (acc[2])      gnt = 3'b100;
            else if (acc[1]) gnt = 3'b010;
            else if (acc[0]) gnt = 3'b001;
        end else begin
            case (ptr)
                2'd1: begin
                    if (acc[1])      gnt = 3'b010;
                    else if (acc[2]) gnt = 3'b100;
                    else if (acc[0]) gnt = 3'b001;
                end
                2'd2: begin
                    if (acc[2])      gnt = 3'b100;
                    else if (acc[0]) gnt = 3'b001;
                    else if (acc[1]) gnt = 3'b010;
                end
                default: begin
                    if (acc[0])      gnt = 3'b001;
                    else if (acc[1]) gnt = 3'b010;
                    else if (acc[2]) gnt = 3'b100;
                end
            endcase
        end
    end

    assign bus.rxwr_wait = bus.wait_in | (acc[0] & ~gnt[0]);
    assign bus.rxrd_wait = bus.wait_in | (acc[1] & ~gnt[1]);
    assign bus.rxrr_wait = bus.wait_in | (acc[2] & ~gnt[2]);

    always_comb begin
        pkt_sel = bus.rxwr_packet;
        if (gnt[1]) pkt_sel = bus.rxrd_packet;
        if (gnt[2]) pkt_sel = bus.rxrr_packet;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= 2'd0;
        end else if (acpt[0]) begin
            ptr <= 2'd1;
        end else if (acpt[1]) begin
            ptr <= 2'd2;
        end else if (acpt[2]) begin
            ptr <= 2'd0;
        end
    end

    // Output register only loads while the consumer is not pushing back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.access_out <= 1'b0;
            bus.packet_out <= '0;
        end else if (!bus.wait_in) begin
            bus.access_out <= |gnt;
            if (|gnt) bus.packet_out <= pkt_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.cnt_wr <= '0;
            bus.cnt_rd <= '0;
            bus.cnt_rr <= '0;
        end else begin
            if (acpt[0]) bus.cnt_wr <= bus.cnt_wr + 1'b1;
            if (acpt[1]) bus.cnt_rd <= bus.cnt_rd + 1'b1;
            if (acpt[2]) bus.cnt_rr <= bus.cnt_rr + 1'b1;
        end
    end
endmodule

// File: tb/tb_emesh_rx_merge.sv
// Randomized bench for emesh_rx_merge: one round-robin and one fixed-priority
// instance, each compared every cycle against a behavioural arbitration model.
module tb_emesh_rx_merge;
    localparam int PW = 104;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wi;
    logic          acc   [2][3];
    logic [PW-1:0] pkt   [2][3];
    bit            taken [2][3];

    always #5 clk = ~clk;

    emesh_rx_merge_if #(.PW(PW), .CW(CW)) b0 ();
    emesh_rx_merge_if #(.PW(PW), .CW(CW)) b1 ();

    emesh_rx_merge #(.PW(PW), .CW(CW), .FIXED(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    emesh_rx_merge #(.PW(PW), .CW(CW), .FIXED(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    assign b0.rxwr_access = acc[0][0];
    assign b0.rxrd_access = acc[0][1];
    assign b0.rxrr_access = acc[0][2];
    assign b0.rxwr_packet = pkt[0][0];
    assign b0.rxrd_packet = pkt[0][1];
    assign b0.rxrr_packet = pkt[0][2];
    assign b0.wait_in     = wi;
    assign b1.rxwr_access = acc[1][0];
    assign b1.rxrd_access = acc[1][1];
    assign b1.rxrr_access = acc[1][2];
    assign b1.rxwr_packet = pkt[1][0];
    assign b1.rxrd_packet = pkt[1][1];
    assign b1.rxrr_packet = pkt[1][2];
    assign b1.wait_in     = wi;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference state: pointer, output register, counters, pending winner.
    int            m_ptr [2];
    bit            m_av  [2];
    logic [PW-1:0] m_pkt [2];
    int            m_cnt [2][3];
    int            m_win [2];
    bit            m_wi;

    function automatic int pick(input int d);
        if (d == 1) begin
            for (int k = 2; k >= 0; k--) if (acc[d][k]) return k;
            return -1;
        end
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (m_ptr[d] + k) % 3;
            if (acc[d][i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0;
            m_av[d]  = 1'b0;
            m_pkt[d] = '0;
            for (int i = 0; i < 3; i++) m_cnt[d][i] = 0;
        end
    endtask

    task automatic model_edge(input int d);
        if (!m_wi) begin
            m_av[d] = (m_win[d] >= 0);
            if (m_win[d] >= 0) begin
                m_pkt[d] = pkt[d][m_win[d]];
                m_cnt[d][m_win[d]] = (m_cnt[d][m_win[d]] + 1) % (1 << CW);
                m_ptr[d] = (m_win[d] + 1) % 3;
                taken[d][m_win[d]] = 1'b1;
            end
        end
    endtask

    function automatic logic dut_wait(input int d, input int i);
        if (d == 0) return (i == 0) ? b0.rxwr_wait : (i == 1) ? b0.rxrd_wait : b0.rxrr_wait;
        return (i == 0) ? b1.rxwr_wait : (i == 1) ? b1.rxrd_wait : b1.rxrr_wait;
    endfunction

    function automatic logic [CW-1:0] dut_cnt(input int d, input int i);
        if (d == 0) return (i == 0) ? b0.cnt_wr : (i == 1) ? b0.cnt_rd : b0.cnt_rr;
        return (i == 0) ? b1.cnt_wr : (i == 1) ? b1.cnt_rd : b1.cnt_rr;
    endfunction

    function automatic logic [PW-1:0] rand_pkt();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[PW-1:0];
    endfunction

    task automatic check_outputs(input string ph);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_access_out", ph, d),
                PW'(d == 0 ? b0.access_out : b1.access_out), PW'(m_av[d]));
            chk($sformatf("%s_d%0d_packet_out", ph, d),
                d == 0 ? b0.packet_out : b1.packet_out, m_pkt[d]);
            for (int i = 0; i < 3; i++)
                chk($sformatf("%s_d%0d_cnt%0d", ph, d, i), PW'(dut_cnt(d, i)), PW'(m_cnt[d][i]));
        end
    endtask

    task automatic check_waits(input int c);
        for (int d = 0; d < 2; d++) begin
            m_win[d] = pick(d);
            for (int i = 0; i < 3; i++)
                chk($sformatf("c%0d_d%0d_wait%0d", c, d, i), PW'(dut_wait(d, i)),
                    PW'(wi || (acc[d][i] && m_win[d] != i)));
        end
    endtask

    task automatic drive(input int c);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 3; i++) begin
                if (taken[d][i]) acc[d][i] = 1'b0;
                taken[d][i] = 1'b0;
            end
        if (c >= 40 && c < 60) begin
            // all sources always requesting; a 4-cycle backpressure window inside
            wi = (c >= 49 && c < 53);
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 3; i++)
                    if (!acc[d][i]) begin acc[d][i] = 1'b1; pkt[d][i] = rand_pkt(); end
        end else if (c >= 60 && c < 70) begin
            wi = 1'b0;
            for (int d = 0; d < 2; d++)
                if (!acc[d][1]) begin acc[d][1] = 1'b1; pkt[d][1] = rand_pkt(); end
        end else begin
            wi = ($urandom_range(0, 3) == 0);
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 3; i++)
                    if (!acc[d][i] && $urandom_range(0, 1) == 1) begin
                        acc[d][i] = 1'b1;
                        pkt[d][i] = rand_pkt();
                    end
        end
    endtask

    initial begin
        reset = 1'b1;
        wi    = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 3; i++) begin
                acc[d][i]   = 1'b0;
                pkt[d][i]   = '0;
                taken[d][i] = 1'b0;
            end
        model_reset();
        m_wi = 1'b0;
        #12;
        check_outputs("reset");
        reset = 1'b0;

        for (int c = 0; c < 400; c++) begin
            drive(c);
            #1;
            check_waits(c);
            m_wi = wi;
            if (c == 100 || c == 250 || c == 45) begin
                #1 reset = 1'b1;
                #1;
                model_reset();
                check_outputs($sformatf("midreset%0d", c));
                #1 reset = 1'b0;
                #1;
                check_waits(c);
            end
            @(posedge clk);
            for (int d = 0; d < 2; d++) model_edge(d);
            #1;
            check_outputs($sformatf("c%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/emesh_rx_merge.md
Name: emesh_rx_merge

Overview:
- Merges the three receive-side master streams leaving the elink (rxwr, rxrd, rxrr) into one emesh stream for a single system-side consumer.
- Uses round-robin arbitration, with one registered output stage and emesh access/wait pushback on every port.
- Sits directly downstream of the elink receiver outputs, in the sys_clk domain.
- Also keeps per-source accept counters for debug readout.

Parameters:
- PW, 104, packet width in bits.
- CW, 16, width of each per-source accept counter.
- FIXED, 0, 1 = fixed priority (rxrr > rxrd > rxwr), 0 = round-robin.

Ports:
- clk  in  1  system clock (sys_clk domain).
- reset  in  1  asynchronous active-high reset.
- rxwr_access  in  1  write stream valid.
- rxwr_packet  in  PW  write packet.
- rxwr_wait  out  1  pushback to write source.
- rxrd_access  in  1  read-request valid.
- rxrd_packet  in  PW  read-request packet.
- rxrd_wait  out  1  pushback to read-request source.
- rxrr_access  in  1  read-response valid.
- rxrr_packet  in  PW  read-response packet.
- rxrr_wait  out  1  pushback to read-response source.
- access_out  out  1  merged stream valid (registered).
- packet_out  out  PW  merged packet (registered).
- wait_in  in  1  pushback from consumer.
- cnt_wr, cnt_rd, cnt_rr  out  CW each  accepted-packet counters.

Interface (already decided):
- One clock; reset is asynchronous and active-high. The clock port is clk and the reset port is reset.

Behaviour:
- Reset values:
  - access_out=0, packet_out=0, all counters=0.
  - Priority pointer=0 (rxwr first). Indices: 0=wr, 1=rd, 2=rr.
- Handshake:
  - An input packet is accepted in a cycle when its access=1 and its wait=0 at the rising edge.
  - Sources hold access and packet until accepted.
- Grant (combinational):
  - Round-robin: the first asserted access scanning from pointer p, then p+1, p+2 (mod 3).
  - FIXED=1: ignore the pointer; order is rr, rd, wr.
  - At most one grant per cycle.
- Input waits: rxX_wait = wait_in | (rxX_access & ~grantX). A source with access=0 may see wait=0.
- Output stage:
  - When wait_in=0: access_out <= |grant; packet_out <= granted packet if any grant, otherwise packet_out holds.
  - When wait_in=1: access_out and packet_out hold unchanged, no input is accepted, and all input waits are 1.
- Latency: exactly 1 cycle from acceptance to access_out.
- Throughput: 1 packet/cycle while wait_in=0.
- Pointer:
  - On acceptance from source i, p <= (i+1) mod 3.
  - Unchanged when there is no acceptance.
  - Wrap 2 -> 0.
- Counters: cntX increments by 1 on each acceptance from X and wraps modulo 2^CW (all-ones -> 0).
- Boundary cases:
  - All three valid simultaneously, wait_in=0 continuous: grant order wr, rd, rr, wr, ... (FIXED=0), each winner accepted once per 3 cycles.
  - Single requester: granted every cycle regardless of pointer.
  - wait_in asserted while access_out=1: the same packet is re-presented until wait_in falls; no duplication, no loss.
  - Reset mid-transfer: asynchronous clear of access_out, counters and pointer; packet_out clears to 0. An in-flight output packet is dropped.
  - No combinational path from wait_in to access_out or packet_out.

Test Plan:
- Reset check: assert reset mid-stream -> access_out=0, packet_out=0, cnt_*=0 immediately; first grant after release goes to rxwr when all are valid.
- Single-source latency: rxrd valid with packet 0xAB..01, wait_in=0 -> rxrd_wait=0, access_out=1 and packet_out=0xAB..01 the next cycle, cnt_rd=1.
- Fair rotation: all three valid for 9 cycles, wait_in=0 -> output sequence wr,rd,rr repeated 3x; each cnt_*=3; non-granted waits high each cycle.
- Backpressure: wait_in=1 for 4 cycles while access_out=1 -> packet_out is stable, all rx*_wait=1, no counter changes; wait_in=0 -> stream resumes with no loss or duplicate.
- FIXED=1 starvation order: rxwr and rxrr valid for 3 cycles -> rxrr granted all 3 cycles; rxwr_wait=1 throughout.
- Counter wrap: CW=4, 17 rxwr acceptances -> cnt_wr = 1.
